// File: rtl/uart_rx_fabric_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fabric_if
//   Byte stream handshake between the fabric UART receiver and its consumer.
//
//   rx_data  : received byte, stable while rx_valid is high
//   rx_valid : a byte is available
//   rx_ready : consumer accepts the byte on an edge where rx_valid && rx_ready
//
//   master : the receiver (drives rx_data / rx_valid)
//   slave  : the consumer (drives rx_ready)
// ---------------------------------------------------------------------------
interface uart_rx_fabric_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fabric.sv
// ---------------------------------------------------------------------------
// uart_rx_fabric
//   8N1 UART receiver for the PL fabric. Decodes the serial line driven by the
//   PS UART, presents each byte on a valid/ready handshake, reports framing
//   errors (one-cycle pulse) and overrun (sticky until clr_err).
//
// Ports:
//   clk       : single clock, everything is synchronous to it
//   rst       : synchronous, active-high reset
//   rx        : asynchronous serial input, idle level 1
//   rx_if     : byte handshake (master side: rx_data, rx_valid out; rx_ready in)
//   frame_err : one-cycle pulse when a stop bit is sampled as 0
//   overrun   : sticky, set when a completed byte had to be dropped
//   clr_err   : clears overrun at the next edge (a coincident set wins)
//   busy      : high whenever the receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_fabric #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  uart_rx_fabric_if.master rx_if,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err,
  output logic             busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  // Two-flop synchronizer; both stages reset to the idle line level so that
  // a reset never looks like a start-bit edge by itself.
  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= rx;
      s2_q        <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitn_d      = bitn_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    // A pending byte is consumed by rx_ready; a delivery below overrides this.
    rx_valid_d  = rx_valid_q & ~rx_if.rx_ready;
    frame_err_d = 1'b0;
    // A new overrun below overrides the clear.
    overrun_d   = overrun_q & ~clr_err;

    unique case (state_q)
      IDLE: begin
        if (!s2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!s2_q) begin
            state_d = DATA;
            bitn_d  = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in from the top leaves it in bit 0.
          shreg_d = {s2_q, shreg_q[7:1]};
          if (bitn_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (s2_q) begin
            // Back in IDLE at the stop-bit midpoint so a start bit that
            // follows with no idle time is still caught.
            state_d = IDLE;
            if (!rx_valid_q || rx_if.rx_ready) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            // Bad stop bit; wait for the line to recover so a held-low
            // (break) line reports only once.
            state_d     = WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        if (s2_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: doc/uart_rx_fabric.md
# uart_rx_fabric

PL-fabric 8N1 UART receiver. It decodes the serial stream that the PS-side UART drives out on `ck_io[1]`, and presents each received byte on a valid/ready handshake to fabric logic. It also reports framing errors and overrun. It sits next to the PS wrapper in the Zynq top, with its serial input tied to the looped-back or header-wired UART TX line.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Must be at least 4.
- `HALF` (localparam) = `CLKS_PER_BIT/2`, integer division.

Ports:
- `clk` in 1: single clock. Everything in the block is synchronous to it.
- `rst` in 1: reset is synchronous and active-high.
- `rx` in 1: asynchronous serial input. Idle level is 1.
- `rx_data` out 8: received byte. Held stable while `rx_valid` is 1.
- `rx_valid` out 1: a byte is available.
- `rx_ready` in 1: the consumer accepts the byte at any edge where `rx_valid && rx_ready`.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled as 0.
- `overrun` out 1: sticky flag. Set when a completed byte is dropped.
- `clr_err` in 1: clears `overrun`.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation

Input synchronizer:
- Two-flop chain `rx` → `s1` → `s2`.
- Both flops reset to 1.
- The FSM uses only `s2`.

FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Supporting registers:
- `cnt`: `$clog2(CLKS_PER_BIT)` bits.
- `bitn`: 3 bits.
- `shreg`: 8 bits.

State behaviour:
- **IDLE:** when `s2 == 0`, go to START with `cnt = 0`.
- **START:** increment `cnt`. At `cnt == HALF-1`, sample `s2`:
  - 0: go to DATA with `cnt = 0`, `bitn = 0`.
  - 1: glitch. Return to IDLE with no output and no error.
- **DATA:** increment `cnt`. At `cnt == CLKS_PER_BIT-1`:
  - Shift `s2` into `shreg` MSB-first-in, so bit 0 (the first received bit) ends in `shreg[0]`. Reception is LSB first.
  - Set `cnt = 0`.
  - After the 8th bit (`bitn == 7`), go to STOP. Otherwise increment `bitn`.
- **STOP:** at `cnt == CLKS_PER_BIT-1`, sample `s2`:
  - 1, byte delivery:
    - If `rx_valid == 0`, or `rx_ready == 1` this cycle: `rx_data <= shreg`, `rx_valid <= 1`.
    - Otherwise keep the old `rx_data`/`rx_valid`, drop the new byte, and set `overrun <= 1`.
    - Go to IDLE.
  - 0: pulse `frame_err` for one cycle, deliver nothing, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `s2 == 1`, then go to IDLE. This covers a break condition: a held-low line yields exactly one `frame_err` and no further bytes.

Handshake:
- `rx_valid` clears at an edge with `rx_ready == 1`, unless a new byte is delivered at that same edge, in which case it stays 1 and `rx_data` updates.
- `rx_ready` while `rx_valid == 0` is ignored.

Errors:
- `clr_err` clears `overrun` at the next edge.
- If `clr_err` coincides with a new overrun, set wins.

Reset values:
- `rx_data = 0`, `rx_valid = 0`, `frame_err = 0`, `overrun = 0`, `busy = 0`.
- FSM = IDLE, `cnt = 0`, `bitn = 0`, `s1 = s2 = 1`.
- Reset mid-frame abandons the frame. Afterwards the FSM resynchronizes on the next 1→0 transition seen after `s2` has been 1.

## Timing

- Edge 0 is the first rising edge at which `rx == 0` is captured in `s1`.
  - Edge 2: IDLE → START.
  - Start bit verified at edge 2+HALF.
  - Data bit k sampled at edge 2+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at edge 2+HALF+9·CLKS_PER_BIT.
  - `rx_valid` and `rx_data` are visible after edge 2+HALF+9·CLKS_PER_BIT, which is edge 4125 for the default.
- `frame_err` is high for exactly the one cycle following the stop-sample edge.
- Back-to-back frames with zero idle time are received without loss, because the FSM is back in IDLE at the stop-bit midpoint.
- Tolerated baud mismatch is at least ±3 % with `CLKS_PER_BIT >= 16`.
- Throughput: one byte per 10·CLKS_PER_BIT cycles.

## Test plan

All scenarios use `CLKS_PER_BIT = 16`, so `HALF = 8`.

1. **Single byte:** send 0xA5 with `rx_ready = 1`. `rx_valid` pulses for 1 cycle after edge 154 with `rx_data = 0xA5`. `frame_err = 0`, `overrun = 0`.
2. **Back-to-back with backpressure:** send 0x00, 0xFF, 0x3C back-to-back, `rx_ready = 0` throughout. Expect `rx_data = 0x00`, `rx_valid` held at 1, `overrun = 1` after the 2nd stop bit. Then pulse `clr_err` → `overrun = 0`.
3. **Handshake collision:** `rx_ready` asserted exactly at the stop-sample edge of a second byte 0x5A, while the first byte 0x11 is still pending. `rx_valid` stays 1, `rx_data = 0x5A`, `overrun = 0`.
4. **Framing error and break:** send 0x81 with stop bit 0, followed by the line held low for 40 bit times. Exactly one `frame_err` pulse, no `rx_valid`. Then send 0x42 after the line returns high → `rx_data = 0x42`.
5. **Glitch rejection:** apply a 3-cycle low pulse on an idle line. `busy` rises then falls, no `rx_valid`, no `frame_err`.
6. **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of 0xC3. All outputs read reset values. The next frame 0x7E is received correctly.
